data_line_xfer: RTL and testbench

//  Line-transfer sequencer for the data RAM's 128-bit "all" port. On command it

---
 rtl/data_line_xfer_pkg.sv | 17 +
 rtl/data_line_xfer.sv | 123 ++++++++++++
 tb/tb_data_line_xfer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_line_xfer_pkg.sv
// Shared definitions for the data RAM line-transfer sequencer: FSM state
// encoding and transfer direction codes.
package data_line_xfer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_RD   = 3'd2,
        ST_CAP  = 3'd3,
        ST_OUT  = 3'd4,
        ST_DONE = 3'd5
    } xfer_state_t;

    localparam logic DIR_FILL  = 1'b0;
    localparam logic DIR_FLUSH = 1'b1;

endpackage

// File: rtl/data_line_xfer.sv
// Line-transfer sequencer: fills N lines from the external stream into the data
// RAM "all" port, or flushes N lines from the RAM out to the external stream.
module data_line_xfer
    import data_line_xfer_pkg::*;
#(
    parameter int DWIDTH = 11,
    localparam int LW = DWIDTH - 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_dir,
    input  logic [LW-1:0] cmd_line,
    input  logic [LW-1:0] cmd_cnt,
    input  logic          ext_rvalid,
    input  logic [127:0]  ext_rdata,
    output logic          ext_rready,
    output logic          ext_wvalid,
    output logic [127:0]  ext_wdata,
    input  logic          ext_wready,
    output logic [LW-1:0] ram_radr_all,
    output logic          ram_ren_all,
    input  logic [127:0]  ram_rdata_all,
    output logic [LW-1:0] ram_wadr_all,
    output logic [127:0]  ram_wdata_all,
    output logic          ram_wen_all,
    output logic          cpu_stall,
    output logic          xfer_done
);

    xfer_state_t   state_q, state_d;
    logic [LW-1:0] line_q, line_d;
    logic [LW-1:0] rem_q, rem_d;
    logic [127:0]  wdata_q, wdata_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            line_q  <= '0;
            rem_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            rem_q   <= rem_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        line_d        = line_q;
        rem_d         = rem_q;
        wdata_d       = wdata_q;
        ext_rready    = 1'b0;
        ext_wvalid    = 1'b0;
        ram_radr_all  = '0;
        ram_ren_all   = 1'b0;
        ram_wadr_all  = '0;
        ram_wdata_all = '0;
        ram_wen_all   = 1'b0;
        xfer_done     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    line_d  = cmd_line;
                    rem_d   = cmd_cnt;
                    state_d = (cmd_dir == DIR_FLUSH) ? ST_RD : ST_FILL;
                end
            end
            // Fill beats are written straight through to the RAM in the
            // cycle they arrive, giving one line per cycle.
            ST_FILL: begin
                ext_rready = 1'b1;
                if (ext_rvalid) begin
                    ram_wen_all   = 1'b1;
                    ram_wadr_all  = line_q;
                    ram_wdata_all = ext_rdata;
                    line_d        = line_q + 1'b1;
                    rem_d         = rem_q - 1'b1;
                    if (rem_q == '0) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RD: begin
                ram_ren_all  = 1'b1;
                ram_radr_all = line_q;
                state_d      = ST_CAP;
            end
            // RAM data lands one cycle after ren; the port stays claimed so
            // the CPU cannot disturb the read in flight.
            ST_CAP: begin
                ram_ren_all  = 1'b1;
                ram_radr_all = line_q;
                wdata_d      = ram_rdata_all;
                state_d      = ST_OUT;
            end
            ST_OUT: begin
                ext_wvalid = 1'b1;
                if (ext_wready) begin
                    line_d  = line_q + 1'b1;
                    rem_d   = rem_q - 1'b1;
                    state_d = (rem_q == '0) ? ST_DONE : ST_RD;
                end
            end
            ST_DONE: begin
                xfer_done = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ext_wdata = wdata_q;
    assign cmd_ready = (state_q == ST_IDLE);
    assign cpu_stall = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule

// File: tb/tb_data_line_xfer.sv
// Directed bench for data_line_xfer: fill, flush with back-pressure, address
// wrap, busy command rejection and asynchronous reset in mid-transfer.
module tb_data_line_xfer;

    localparam int DWIDTH = 11;
    localparam int LW = DWIDTH - 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_dir;
    logic [LW-1:0] cmd_line;
    logic [LW-1:0] cmd_cnt;
    logic          ext_rvalid;
    logic [127:0]  ext_rdata;
    logic          ext_rready;
    logic          ext_wvalid;
    logic [127:0]  ext_wdata;
    logic          ext_wready;
    logic [LW-1:0] ram_radr_all;
    logic          ram_ren_all;
    logic [127:0]  ram_rdata_all;
    logic [LW-1:0] ram_wadr_all;
    logic [127:0]  ram_wdata_all;
    logic          ram_wen_all;
    logic          cpu_stall;
    logic          xfer_done;

    int n_cmp = 0;
    int n_err = 0;

    data_line_xfer #(.DWIDTH(DWIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .cmd_line(cmd_line), .cmd_cnt(cmd_cnt),
        .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata), .ext_rready(ext_rready),
        .ext_wvalid(ext_wvalid), .ext_wdata(ext_wdata), .ext_wready(ext_wready),
        .ram_radr_all(ram_radr_all), .ram_ren_all(ram_ren_all),
        .ram_rdata_all(ram_rdata_all),
        .ram_wadr_all(ram_wadr_all), .ram_wdata_all(ram_wdata_all),
        .ram_wen_all(ram_wen_all),
        .cpu_stall(cpu_stall), .xfer_done(xfer_done)
    );

    always #5 clk = ~clk;

    // {cmd_ready, cpu_stall, ram_wen_all, ram_ren_all, ext_rready, ext_wvalid, xfer_done}
    logic [6:0] ctl;
    assign ctl = {cmd_ready, cpu_stall, ram_wen_all, ram_ren_all, ext_rready, ext_wvalid, xfer_done};

    localparam logic [6:0] C_IDLE = 7'b1000000;
    localparam logic [6:0] C_FILL = 7'b0100100;
    localparam logic [6:0] C_FWR  = 7'b0110100;
    localparam logic [6:0] C_RD   = 7'b0101000;
    localparam logic [6:0] C_OUT  = 7'b0100010;
    localparam logic [6:0] C_DONE = 7'b0000001;

    function automatic logic [127:0] pat(input logic [LW-1:0] a);
        logic [31:0] w;
        w = {{(32-LW){1'b0}}, a};
        return {32'hA5A5_0000 | w, ~w, 32'h1234_5678 ^ w, w};
    endfunction

    // RAM model: read data appears one cycle after ren
    always @(posedge clk) begin
        if (ram_ren_all) ram_rdata_all <= pat(ram_radr_all);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_cmp++;
        if (ctl !== C_IDLE) begin
            n_err++; $display("FAIL reset_ctl: got %b want %b", ctl, C_IDLE);
        end
        n_cmp++;
        if ({ram_radr_all, ram_wadr_all, ram_wdata_all, ext_wdata} !== '0) begin
            n_err++; $display("FAIL reset_data: radr %h wadr %h wdata %h ext_wdata %h want 0",
                              ram_radr_all, ram_wadr_all, ram_wdata_all, ext_wdata);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        logic [127:0] d;
        cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_line = 9'h010; cmd_cnt = 9'd3;
        @(negedge clk);
        n_cmp++;
        if (ctl !== C_IDLE) begin
            n_err++; $display("FAIL fill_accept: got %b want %b", ctl, C_IDLE);
        end
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = {4{32'hD0D0_0000 + 32'(i)}};
            ext_rvalid = 1'b1; ext_rdata = d;
            @(negedge clk);
            n_cmp++;
            if (ctl !== C_FWR) begin
                n_err++; $display("FAIL fill_ctl[%0d]: got %b want %b", i, ctl, C_FWR);
            end
            n_cmp++;
            if (ram_wadr_all !== 9'(16 + i) || ram_wdata_all !== d) begin
                n_err++; $display("FAIL fill_wr[%0d]: got %h/%h want %h/%h",
                                  i, ram_wadr_all, ram_wdata_all, 9'(16 + i), d);
            end
            tick();
        end
        ext_rvalid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ctl !== C_DONE) begin
            n_err++; $display("FAIL fill_done: got %b want %b", ctl, C_DONE);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (ctl !== C_IDLE) begin
            n_err++; $display("FAIL fill_idle: got %b want %b", ctl, C_IDLE);
        end
        tick();
    endtask

    task automatic test_flush_busy();
        logic [LW-1:0] ln;
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_line = 9'h005; cmd_cnt = 9'd1;
        tick();
        // a second command offered while busy must be ignored
        cmd_dir = 1'b0; cmd_line = 9'h033; cmd_cnt = 9'd0;
        for (int k = 0; k < 2; k++) begin
            ln = 9'(5 + k);
            @(negedge clk);
            n_cmp++;
            if (ctl !== C_RD || ram_radr_all !== ln) begin
                n_err++; $display("FAIL flush_rd[%0d]: got %b/%h want %b/%h", k, ctl, ram_radr_all, C_RD, ln);
            end
            tick();
            cmd_valid = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (ctl !== C_RD || ram_radr_all !== ln) begin
                n_err++; $display("FAIL flush_cap[%0d]: got %b/%h want %b/%h", k, ctl, ram_radr_all, C_RD, ln);
            end
            tick();
            for (int w = 0; w < 4; w++) begin
                ext_wready = (w == 3);
                @(negedge clk);
                n_cmp++;
                if (ctl !== C_OUT || ext_wdata !== pat(ln)) begin
                    n_err++; $display("FAIL flush_out[%0d.%0d]: got %b/%h want %b/%h",
                                      k, w, ctl, ext_wdata, C_OUT, pat(ln));
                end
                tick();
            end
            ext_wready = 1'b0;
        end
        @(negedge clk);
        n_cmp++;
        if (ctl !== C_DONE) begin
            n_err++; $display("FAIL flush_done: got %b want %b", ctl, C_DONE);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (ctl !== C_IDLE) begin
                n_err++; $display("FAIL busy_no_second[%0d]: got %b want %b", i, ctl, C_IDLE);
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_line = 9'h1FF; cmd_cnt = 9'd1;
        tick();
        cmd_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ctl !== C_FILL) begin
            n_err++; $display("FAIL wrap_gap: got %b want %b", ctl, C_FILL);
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            ext_rvalid = 1'b1; ext_rdata = {4{32'hBEEF_0000 + 32'(i)}};
            @(negedge clk);
            n_cmp++;
            if (ctl !== C_FWR || ram_wadr_all !== ((i == 0) ? 9'h1FF : 9'h000)) begin
                n_err++; $display("FAIL wrap_wr[%0d]: got %b/%h want %b/%h",
                                  i, ctl, ram_wadr_all, C_FWR, (i == 0) ? 9'h1FF : 9'h000);
            end
            tick();
        end
        ext_rvalid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ctl !== C_DONE) begin
            n_err++; $display("FAIL wrap_done: got %b want %b", ctl, C_DONE);
        end
        tick();
    endtask

    task automatic test_single();
        cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_line = 9'h042; cmd_cnt = 9'd0;
        tick();
        cmd_valid = 1'b0;
        ext_rvalid = 1'b1; ext_rdata = {4{32'h5151_5151}};
        @(negedge clk);
        n_cmp++;
        if (ctl !== C_FWR || ram_wadr_all !== 9'h042) begin
            n_err++; $display("FAIL single_wr: got %b/%h want %b/042", ctl, ram_wadr_all, C_FWR);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (ctl !== C_DONE) begin
            n_err++; $display("FAIL single_done: got %b want %b", ctl, C_DONE);
        end
        ext_rvalid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_line = 9'h020; cmd_cnt = 9'd3;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ext_rvalid = 1'b1; ext_rdata = {4{32'h7777_0000 + 32'(i)}};
            @(negedge clk);
            n_cmp++;
            if (ctl !== C_FWR || ram_wadr_all !== 9'(32 + i)) begin
                n_err++; $display("FAIL rstmid_wr[%0d]: got %b/%h want %b/%h",
                                  i, ctl, ram_wadr_all, C_FWR, 9'(32 + i));
            end
            tick();
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (ctl !== C_IDLE) begin
            n_err++; $display("FAIL rstmid_ctl: got %b want %b", ctl, C_IDLE);
        end
        n_cmp++;
        if ({ram_wadr_all, ram_wdata_all, ext_wdata} !== '0) begin
            n_err++; $display("FAIL rstmid_data: wadr %h wdata %h ext_wdata %h want 0",
                              ram_wadr_all, ram_wdata_all, ext_wdata);
        end
        tick();
        rst_n = 1'b1;
        ext_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (ctl !== C_IDLE) begin
                n_err++; $display("FAIL rstmid_after[%0d]: got %b want %b", i, ctl, C_IDLE);
            end
            tick();
        end
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_line = '0; cmd_cnt = '0;
        ext_rvalid = 1'b0; ext_rdata = '0; ext_wready = 1'b0;
        test_reset();
        test_fill();
        test_flush_busy();
        test_wrap();
        test_single();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
